// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes and a one-cycle tc pulse.
// Latency: a load accepted at edge k shows q=N after edge k; first decrement at the next enabled edge.
// Backpressure: load_ready is low while running or while abort is asserted; loads are not queued.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (0 = reset)
//   clk_enable  count-enable strobe; the count holds while low
//   load_valid  load request, qualifies load_value and periodic
//   load_ready  high when a load can be accepted (IDLE and no abort)
//   load_value  start/reload value N
//   periodic    mode captured with the load: 1 = auto-reload, 0 = one-shot
//   abort       stop the current run without a tc pulse
//   q           current count value
//   busy        high while a run is in progress
//   tc          registered terminal-count pulse, one cycle wide
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic             mode;
  logic             tc_r;

  // Abort masks ready so a load arriving with abort in IDLE is refused.
  assign load_ready = (state == IDLE) && !abort;
  assign q          = count;
  assign busy       = (state == RUN);
  assign tc         = tc_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      tc_r   <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            if (load_value != '0) begin
              count  <= load_value;
              reload <= load_value;
              mode   <= periodic;
              state  <= RUN;
            end else begin
              // A zero load expires immediately regardless of mode.
              count <= '0;
              tc_r  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort has priority over an expiry on the same edge.
          if (abort) begin
            count <= '0;
            state <= IDLE;
          end else if (clk_enable) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              // count is never 0 in RUN, so this is the count==1 expiry.
              tc_r <= 1'b1;
              if (mode) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= IDLE;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  logic       clk;
  logic       reset;
  logic       clk_enable;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       periodic;
  logic       abort;
  logic [7:0] q;
  logic       busy;
  logic       tc;

  int checks;
  int errors;

  down_counter_timer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .periodic   (periodic),
    .abort      (abort),
    .q          (q),
    .busy       (busy),
    .tc         (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are sampled and inputs changed here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a value (one edge), leaving load_valid low afterwards.
  task automatic do_load(input logic [7:0] n, input logic per);
    load_value = n;
    periodic   = per;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    // Power-on reset state.
    checks++;
    if (q !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_init q=%0d busy=%0b tc=%0b required q=0 busy=0 tc=0", q, busy, tc);
    end
    reset = 1'b1;
    step();
    clk_enable = 1'b0;
    do_load(8'd5, 1'b0);
    checks++;
    if (q !== 8'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload q=%0d busy=%0b required q=5 busy=1", q, busy);
    end
    // Assert reset between edges: must act without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_async q=%0d busy=%0b tc=%0b required q=0 busy=0 tc=0", q, busy, tc);
    end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release load_ready=%0b required 1", load_ready);
    end
    step();
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_q [3];
    logic       exp_tc[3];
    int         pulses;
    exp_q[0] = 8'd2; exp_q[1] = 8'd1; exp_q[2] = 8'd0;
    exp_tc[0] = 1'b0; exp_tc[1] = 1'b0; exp_tc[2] = 1'b1;
    pulses = 0;
    clk_enable = 1'b1;
    do_load(8'd3, 1'b0);
    checks++;
    if (q !== 8'd3 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_load q=%0d busy=%0b tc=%0b required q=3 busy=1 tc=0", q, busy, tc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (tc === 1'b1) pulses++;
      checks++;
      if (q !== exp_q[i] || tc !== exp_tc[i] || busy !== (i < 2)) begin
        errors++;
        $display("FAIL oneshot_step%0d q=%0d tc=%0b busy=%0b required q=%0d tc=%0b busy=%0b",
                 i, q, tc, busy, exp_q[i], exp_tc[i], (i < 2));
      end
    end
    step();
    step();
    if (tc === 1'b1) pulses++;
    checks++;
    if (pulses !== 1 || q !== 8'd0) begin
      errors++;
      $display("FAIL oneshot_single_tc pulses=%0d q=%0d required pulses=1 q=0", pulses, q);
    end
  endtask

  task automatic test_periodic();
    int         pulses;
    logic [7:0] eq;
    logic       etc;
    pulses = 0;
    clk_enable = 1'b1;
    do_load(8'd4, 1'b1);
    checks++;
    if (q !== 8'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL periodic_load q=%0d busy=%0b required q=4 busy=1", q, busy);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      eq  = 8'(4 - ((i + 1) % 4));
      etc = ((i + 1) % 4 == 0);
      if (tc === 1'b1) pulses++;
      checks++;
      if (q !== eq || tc !== etc || busy !== 1'b1) begin
        errors++;
        $display("FAIL periodic_step%0d q=%0d tc=%0b busy=%0b required q=%0d tc=%0b busy=1",
                 i, q, tc, busy, eq, etc);
      end
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL periodic_pulses got=%0d required 3", pulses);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (q !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL periodic_abort q=%0d busy=%0b tc=%0b required q=0 busy=0 tc=0", q, busy, tc);
    end
  endtask

  task automatic test_enable();
    clk_enable = 1'b1;
    do_load(8'd2, 1'b0);
    checks++;
    if (q !== 8'd2) begin
      errors++;
      $display("FAIL enable_load q=%0d required 2", q);
    end
    step();
    checks++;
    if (q !== 8'd1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL enable_first q=%0d tc=%0b required q=1 tc=0", q, tc);
    end
    clk_enable = 1'b0;
    step();
    checks++;
    if (q !== 8'd1 || tc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enable_hold q=%0d tc=%0b busy=%0b required q=1 tc=0 busy=1", q, tc, busy);
    end
    clk_enable = 1'b1;
    step();
    checks++;
    if (q !== 8'd0 || tc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_expire q=%0d tc=%0b busy=%0b required q=0 tc=1 busy=0", q, tc, busy);
    end
    step();
  endtask

  task automatic test_edge_loads();
    int pulses;
    int bad;
    clk_enable = 1'b1;
    do_load(8'd0, 1'b1);
    checks++;
    if (q !== 8'd0 || tc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_load q=%0d tc=%0b busy=%0b required q=0 tc=1 busy=0", q, tc, busy);
    end
    step();
    checks++;
    if (tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_load_after tc=%0b busy=%0b required tc=0 busy=0", tc, busy);
    end
    do_load(8'd255, 1'b0);
    checks++;
    if (q !== 8'd255 || busy !== 1'b1) begin
      errors++;
      $display("FAIL max_load q=%0d busy=%0b required q=255 busy=1", q, busy);
    end
    pulses = 0;
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (tc === 1'b1) pulses++;
      if (q !== 8'(255 - i) || tc !== (i == 255)) bad++;
    end
    checks++;
    if (bad !== 0 || pulses !== 1) begin
      errors++;
      $display("FAIL max_run bad_steps=%0d pulses=%0d required 0 and 1", bad, pulses);
    end
    step();
    checks++;
    if (q !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL max_nowrap q=%0d busy=%0b tc=%0b required q=0 busy=0 tc=0", q, busy, tc);
    end
  endtask

  task automatic test_abort_collision();
    // Abort beats expiry at q=1 with enable high.
    clk_enable = 1'b1;
    do_load(8'd2, 1'b1);
    step();
    checks++;
    if (q !== 8'd1) begin
      errors++;
      $display("FAIL abort_setup q=%0d required 1", q);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (q !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_expiry q=%0d tc=%0b busy=%0b required q=0 tc=0 busy=0", q, tc, busy);
    end
    // Load during RUN is refused.
    clk_enable = 1'b0;
    do_load(8'd5, 1'b0);
    load_value = 8'd9;
    load_valid = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_ready load_ready=%0b required 0", load_ready);
    end
    step();
    load_valid = 1'b0;
    checks++;
    if (q !== 8'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_load_ignored q=%0d busy=%0b required q=5 busy=1", q, busy);
    end
    abort = 1'b1;
    step();
    // Abort plus load in IDLE: ready forced low, nothing loaded.
    load_value = 8'd7;
    load_valid = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort_ready load_ready=%0b required 0", load_ready);
    end
    step();
    load_valid = 1'b0;
    abort = 1'b0;
    #1;
    checks++;
    if (q !== 8'd0 || busy !== 1'b0 || tc !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_abort_noload q=%0d busy=%0b tc=%0b ready=%0b required q=0 busy=0 tc=0 ready=1",
               q, busy, tc, load_ready);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    clk_enable = 1'b0;
    load_valid = 1'b0;
    load_value = 8'd0;
    periodic   = 1'b0;
    abort      = 1'b0;
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_enable();
    test_edge_loads();
    test_abort_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
